// File: rtl/joypad_port.sv
// joypad_port: NES controller port on the cpu_2a03 bus ($4016 / $4017).
// Holds the controller latch bit, snapshots the pads into shift registers and
// returns one button bit per completed read, with an open-bus upper byte of 8'h40.
// Optional feature macro: JOYPAD_PORT2_EN builds the pad 2 path; when it is
// undefined, $4017 reads return 8'h40 with data_oe still asserted.
module joypad_port #(
  parameter int unsigned SYNC_STAGES = 2  // 2 or 3
) (
  input  logic       clock,
  input  logic       nreset,
  input  logic       addr4016w,
  input  logic       naddr4016r,
  input  logic       naddr4017r,
  input  logic [7:0] data_in,
  input  logic [7:0] pad1_buttons,
  input  logic [7:0] pad2_buttons,
  output logic [7:0] data_out,
  output logic       data_oe
);

  logic [SYNC_STAGES-1:0][7:0] r_sync1;
  logic [7:0]                  w_sync1;
  logic                        r_latch;
  logic [7:0]                  r_sr1;
  logic                        r_r1;
  logic                        w_rd1_done;
  logic                        w_bit1;
  logic                        w_bit2;
  logic                        w_unused;

  assign w_sync1    = r_sync1[SYNC_STAGES-1];
  assign w_rd1_done = ~r_r1 & naddr4016r;
  // While latched, reads see the live synchronized A button.
  assign w_bit1     = r_latch ? w_sync1[0] : r_sr1[0];

  // Pad 1 button synchronizer chain
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_sync1 <= '0;
    end else begin
      r_sync1 <= {r_sync1[SYNC_STAGES-2:0], pad1_buttons};
    end
  end

  // Controller latch bit written through $4016
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_latch <= 1'b0;
    end else if (addr4016w) begin
      r_latch <= data_in[0];
    end
  end

  // Registered $4016 strobe for read-completion (rising) edge detection
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_r1 <= 1'b1;
    end else begin
      r_r1 <= naddr4016r;
    end
  end

  // Pad 1 shift register: reload while latched, else shift one per completed read
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_sr1 <= 8'hFF;
    end else if (r_latch) begin
      r_sr1 <= w_sync1;
    end else if (w_rd1_done) begin
      r_sr1 <= {1'b1, r_sr1[7:1]};
    end
  end

`ifdef JOYPAD_PORT2_EN
  logic [SYNC_STAGES-1:0][7:0] r_sync2;
  logic [7:0]                  w_sync2;
  logic [7:0]                  r_sr2;
  logic                        r_r2;
  logic                        w_rd2_done;

  assign w_sync2    = r_sync2[SYNC_STAGES-1];
  assign w_rd2_done = ~r_r2 & naddr4017r;
  assign w_bit2     = r_latch ? w_sync2[0] : r_sr2[0];
  assign w_unused   = ^data_in[7:1];

  // Pad 2 button synchronizer chain
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_sync2 <= '0;
    end else begin
      r_sync2 <= {r_sync2[SYNC_STAGES-2:0], pad2_buttons};
    end
  end

  // Registered $4017 strobe for read-completion edge detection
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_r2 <= 1'b1;
    end else begin
      r_r2 <= naddr4017r;
    end
  end

  // Pad 2 shift register, same reload/shift rules as pad 1
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_sr2 <= 8'hFF;
    end else if (r_latch) begin
      r_sr2 <= w_sync2;
    end else if (w_rd2_done) begin
      r_sr2 <= {1'b1, r_sr2[7:1]};
    end
  end
`else
  assign w_bit2   = 1'b0;
  assign w_unused = ^{data_in[7:1], pad2_buttons, naddr4017r & 1'b0};
`endif

  // Read data mux; pad 1 wins when both strobes are low
  always_comb begin
    data_out = 8'h40;
    if (!naddr4016r) begin
      data_out[0] = w_bit1;
    end else if (!naddr4017r) begin
      data_out[0] = w_bit2;
    end
  end

  assign data_oe = ~naddr4016r | ~naddr4017r;

endmodule

// File: tb/tb_joypad_port.sv
// Self-checking bench for joypad_port: directed test-plan steps followed by
// random traffic, all compared against a snapshot/read-count model.
module tb_joypad_port;

  localparam int unsigned Sync = 2;
`ifdef JOYPAD_PORT2_EN
  localparam bit Pad2En = 1'b1;
`else
  localparam bit Pad2En = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       nreset;
  logic       addr4016w;
  logic       naddr4016r;
  logic       naddr4017r;
  logic [7:0] data_in;
  logic [7:0] pad1_buttons;
  logic [7:0] pad2_buttons;
  logic [7:0] data_out;
  logic       data_oe;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  joypad_port #(.SYNC_STAGES(Sync)) dut (
    .clock        (clock),
    .nreset       (nreset),
    .addr4016w    (addr4016w),
    .naddr4016r   (naddr4016r),
    .naddr4017r   (naddr4017r),
    .data_in      (data_in),
    .pad1_buttons (pad1_buttons),
    .pad2_buttons (pad2_buttons),
    .data_out     (data_out),
    .data_oe      (data_oe)
  );

  // Reference model: a pad is a snapshot byte plus a count of reads taken
  // from it; button history gives the value seen Sync edges ago.
  logic [7:0] m_h1 [3];
  logic [7:0] m_h2 [3];
  logic [7:0] m_snap1, m_snap2;
  int         m_cnt1, m_cnt2;
  logic       m_latch, m_p1, m_p2;
  bit         m_in_reset;

  function automatic logic pad_bit(logic [7:0] snap, int cnt);
    return (cnt >= 8) ? 1'b1 : snap[cnt];
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_h1[i] = 8'h00;
      m_h2[i] = 8'h00;
    end
    m_snap1 = 8'h00;
    m_snap2 = 8'h00;
    m_cnt1  = 8;
    m_cnt2  = 8;
    m_latch = 1'b0;
    m_p1    = 1'b1;
    m_p2    = 1'b1;
  endfunction

  function automatic void model_edge();
    logic [7:0] s1, s2;
    logic d1, d2;
    if (m_in_reset) begin
      model_reset();
      return;
    end
    s1 = m_h1[Sync-1];
    s2 = m_h2[Sync-1];
    d1 = !m_p1 && naddr4016r;
    d2 = !m_p2 && naddr4017r;
    if (m_latch) begin
      m_snap1 = s1; m_cnt1 = 0;
      m_snap2 = s2; m_cnt2 = 0;
    end else begin
      if (d1 && m_cnt1 < 8) m_cnt1++;
      if (d2 && m_cnt2 < 8) m_cnt2++;
    end
    if (addr4016w) m_latch = data_in[0];
    m_p1 = naddr4016r;
    m_p2 = naddr4017r;
    for (int i = 2; i > 0; i--) begin
      m_h1[i] = m_h1[i-1];
      m_h2[i] = m_h2[i-1];
    end
    m_h1[0] = pad1_buttons;
    m_h2[0] = pad2_buttons;
  endfunction

  function automatic logic [7:0] exp_data();
    logic b;
    b = 1'b0;
    if (!naddr4016r) begin
      b = m_latch ? m_h1[Sync-1][0] : pad_bit(m_snap1, m_cnt1);
    end else if (!naddr4017r && Pad2En) begin
      b = m_latch ? m_h2[Sync-1][0] : pad_bit(m_snap2, m_cnt2);
    end
    return 8'h40 | {7'd0, b};
  endfunction

  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input int lit);
    logic [7:0] exp;
    logic       exp_oe;
    #1;
    exp    = exp_data();
    exp_oe = !naddr4016r || !naddr4017r;
    checks++;
    assert (data_out === exp) else begin
      errors++;
      $error("FAIL %s data_out: got %h want %h", tag, data_out, exp);
    end
    checks++;
    assert (data_oe === exp_oe) else begin
      errors++;
      $error("FAIL %s data_oe: got %b want %b", tag, data_oe, exp_oe);
    end
    if (lit >= 0) begin
      checks++;
      assert (data_out === 8'(lit)) else begin
        errors++;
        $error("FAIL %s literal: got %h want %h", tag, data_out, 8'(lit));
      end
    end
  endtask

  // port: 0 = $4016, 1 = $4017, 2 = both strobes together
  task automatic rd(input int port, input int len, input string tag, input int lit);
    naddr4016r = (port == 1);
    naddr4017r = (port == 0);
    chk(tag, lit);
    repeat (len) step();
    naddr4016r = 1'b1;
    naddr4017r = 1'b1;
    step();
  endtask

  task automatic wr(input logic [7:0] v);
    addr4016w = 1'b1;
    data_in   = v;
    step();
    addr4016w = 1'b0;
    data_in   = 8'($urandom);
  endtask

  task automatic do_reset(input int n);
    nreset     = 1'b0;
    m_in_reset = 1'b1;
    model_reset();
    repeat (n) step();
    nreset     = 1'b1;
    m_in_reset = 1'b0;
  endtask

  task automatic latch_cycle();
    repeat (3) step();
    wr(8'h01);
    wr(8'h00);
  endtask

  logic [7:0] basic_pat;

  initial begin
    nreset       = 1'b0;
    m_in_reset   = 1'b1;
    addr4016w    = 1'b0;
    naddr4016r   = 1'b1;
    naddr4017r   = 1'b1;
    data_in      = 8'h00;
    pad1_buttons = 8'h00;
    pad2_buttons = 8'h00;
    model_reset();

    // Reset state with a strobe pulsed during reset
    @(negedge clock);
    chk("rst_idle", 8'h40);
    naddr4016r = 1'b0;
    chk("rst_strobe", 8'h41);
    step();
    naddr4016r = 1'b1;
    step();
    nreset     = 1'b1;
    m_in_reset = 1'b0;
    for (int i = 0; i < 9; i++) rd(0, 1, "rst_read", 8'h41);

    // Basic eight-bit sequence, then ones
    pad1_buttons = 8'b1010_0101;
    basic_pat    = 8'b1010_0101;
    latch_cycle();
    for (int i = 0; i < 8; i++) rd(0, 1, "basic", 8'h40 | {7'd0, basic_pat[i]});
    rd(0, 1, "basic_9", 8'h41);
    rd(0, 1, "basic_10", 8'h41);

    // Held latch returns live A and never shifts
    pad1_buttons = 8'h01;
    repeat (3) step();
    wr(8'h01);
    for (int i = 0; i < 5; i++) rd(0, 1, "held", 8'h41);
    pad1_buttons = 8'h02;
    repeat (3) step();
    rd(0, 1, "held_rel", 8'h40);
    wr(8'h00);
    rd(0, 1, "held_a", 8'h40);
    rd(0, 1, "held_b", 8'h41);

    // Long strobe on $4017 shifts exactly once
    pad2_buttons = 8'h02;
    latch_cycle();
    rd(1, 4, "long_1", 8'h40);
    rd(1, 1, "long_2", Pad2En ? 8'h41 : 8'h40);

    // Simultaneous strobes: pad 1 shown, both shift
    pad1_buttons = 8'h01;
    pad2_buttons = 8'h02;
    latch_cycle();
    rd(2, 1, "both", 8'h41);
    rd(0, 1, "sim_p1b", 8'h40);
    rd(1, 1, "sim_p2b", Pad2En ? 8'h41 : 8'h40);

    // Reset mid-sequence discards shift state
    pad1_buttons = 8'h00;
    pad2_buttons = 8'h00;
    latch_cycle();
    for (int i = 0; i < 3; i++) rd(0, 1, "mid_pre", 8'h40);
    do_reset(2);
    rd(0, 1, "mid_post", 8'h41);
    rd(1, 1, "mid_4017", Pad2En ? 8'h41 : 8'h40);

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0: pad1_buttons = 8'($urandom);
        1: pad2_buttons = 8'($urandom);
        2: wr(8'($urandom));
        3: step();
        9: if ($urandom_range(0, 9) == 0) do_reset(1 + $urandom_range(0, 1)); else step();
        default: rd($urandom_range(0, 2), 1 + $urandom_range(0, 2), "rand", -1);
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
